// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
// Bus bundle for the shared data-memory port.
//
// Signal groups:
//   p0_*  pipeline memory stage (push/pop/write/read, stall, load data)
//   p1_*  auxiliary requester (req/ack handshake, read data)
//   mem_* data-memory strobes, address, write data and read data
//
// Modports:
//   slave  - the arbiter's view (requests in, grants/memory strobes out)
//   master - the environment's view (requesters plus the memory itself)
// ----------------------------------------------------------------------------
interface dmem_arbiter_if;
    // Port 0: memory stage
    logic        p0_read;
    logic        p0_write;
    logic        p0_push;
    logic        p0_pop;
    logic [15:0] p0_addr;
    logic [15:0] p0_wdata;
    logic        p0_stall;
    logic [15:0] p0_rdata;
    logic        p0_rvalid;

    // Port 1: debug / DMA loader
    logic        p1_req;
    logic        p1_we;
    logic [15:0] p1_addr;
    logic [15:0] p1_wdata;
    logic        p1_ack;
    logic [15:0] p1_rdata;
    logic        p1_rvalid;

    // Data memory
    logic        mem_cs;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport slave (
        input  p0_read, p0_write, p0_push, p0_pop, p0_addr, p0_wdata,
        output p0_stall, p0_rdata, p0_rvalid,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_ack, p1_rdata, p1_rvalid,
        output mem_cs, mem_we, mem_re, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p0_read, p0_write, p0_push, p0_pop, p0_addr, p0_wdata,
        input  p0_stall, p0_rdata, p0_rvalid,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata, p1_rvalid,
        input  mem_cs, mem_we, mem_re, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Owns the single data-memory port shared by the pipeline memory stage
// (port 0) and an auxiliary requester (port 1). Keeps the stack pointer,
// resolves push/pop addressing, flags stack overflow/underflow, and
// arbitrates with port-0 priority plus a starvation guard for port 1.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   io_bus       dmem_arbiter_if.slave (port 0, port 1 and memory signals)
//   o_sp         current stack pointer
//   o_stack_ovf  sticky: push attempted below STACK_FLOOR
//   o_stack_unf  sticky: pop attempted on an empty stack
//
// Parameters:
//   SP_RESET      stack pointer after reset (top of stack, empty)
//   STACK_FLOOR   lowest legal stack address
//   STARVE_LIMIT  cycles port 1 may wait before being forced through (1..15)
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter logic [15:0] SP_RESET     = 16'h0FFF,
    parameter logic [15:0] STACK_FLOOR  = 16'h0800,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_arbiter_if.slave        io_bus,
    output logic [15:0]          o_sp,
    output logic                 o_stack_ovf,
    output logic                 o_stack_unf
);

    localparam int unsigned     CNT_W       = 4;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    // A push is refused when it would move sp below the floor.
    localparam logic [15:0]     SP_OVF_TRIP = STACK_FLOOR - 16'd1;

    // Owner of the read issued last cycle. P0_ZERO is an underflowed pop:
    // port 0 still gets its rvalid pulse, but with zero data and no memory
    // access behind it.
    localparam logic [1:0] OWN_NONE    = 2'd0;
    localparam logic [1:0] OWN_P0      = 2'd1;
    localparam logic [1:0] OWN_P1      = 2'd2;
    localparam logic [1:0] OWN_P0_ZERO = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [15:0]      r_sp;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [1:0]       r_rd_owner;
    logic             r_stack_ovf;
    logic             r_stack_unf;
    logic [15:0]      r_p0_rdata;
    logic [15:0]      r_p1_rdata;

    // ------------------------------------------------------------------------
    // Port-0 decode (push > pop > write > read)
    // ------------------------------------------------------------------------
    logic w_p0_push_op;
    logic w_p0_pop_op;
    logic w_p0_write_op;
    logic w_p0_read_op;
    logic w_p0_has_op;

    assign w_p0_push_op  = io_bus.p0_push;
    assign w_p0_pop_op   = !io_bus.p0_push && io_bus.p0_pop;
    assign w_p0_write_op = !io_bus.p0_push && !io_bus.p0_pop && io_bus.p0_write;
    assign w_p0_read_op  = !io_bus.p0_push && !io_bus.p0_pop && !io_bus.p0_write
                           && io_bus.p0_read;
    assign w_p0_has_op   = io_bus.p0_push || io_bus.p0_pop
                           || io_bus.p0_write || io_bus.p0_read;

    // ------------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------------
    logic w_p1_grant;
    logic w_p0_grant;

    // NOTE: grants are gated by rst so every strobe and p1_ack is low for the
    // whole time reset is held, not just after the first clock edge.
    assign w_p1_grant = !rst && io_bus.p1_req
                        && (!w_p0_has_op || (r_starve_cnt == STARVE_MAX));
    assign w_p0_grant = !rst && w_p0_has_op && !w_p1_grant;

    // Stack qualification of the granted port-0 op.
    logic [15:0] w_sp_inc;
    logic        w_push_ok;
    logic        w_push_ovf;
    logic        w_pop_ok;
    logic        w_pop_unf;
    logic        w_write_ok;
    logic        w_read_ok;

    assign w_sp_inc   = r_sp + 16'd1;
    assign w_push_ok  = w_p0_grant && w_p0_push_op && (r_sp != SP_OVF_TRIP);
    assign w_push_ovf = w_p0_grant && w_p0_push_op && (r_sp == SP_OVF_TRIP);
    assign w_pop_ok   = w_p0_grant && w_p0_pop_op  && (r_sp != SP_RESET);
    assign w_pop_unf  = w_p0_grant && w_p0_pop_op  && (r_sp == SP_RESET);
    assign w_write_ok = w_p0_grant && w_p0_write_op;
    assign w_read_ok  = w_p0_grant && w_p0_read_op;

    // ------------------------------------------------------------------------
    // Memory strobes (combinational from grant)
    // ------------------------------------------------------------------------
    logic        w_mem_we;
    logic        w_mem_re;
    logic [15:0] w_mem_addr;
    logic [15:0] w_mem_wdata;

    always_comb begin
        // NOTE: every output gets a default before the branches; an untaken
        // path would otherwise hold its old value and infer a latch.
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_addr  = 16'h0000;
        w_mem_wdata = 16'h0000;

        if (w_p1_grant) begin
            w_mem_we    = io_bus.p1_we;
            w_mem_re    = !io_bus.p1_we;
            w_mem_addr  = io_bus.p1_addr;
            w_mem_wdata = io_bus.p1_wdata;
        end else if (w_push_ok) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_sp;
            w_mem_wdata = io_bus.p0_wdata;
        end else if (w_pop_ok) begin
            w_mem_re    = 1'b1;
            w_mem_addr  = w_sp_inc;
        end else if (w_write_ok) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = io_bus.p0_addr;
            w_mem_wdata = io_bus.p0_wdata;
        end else if (w_read_ok) begin
            w_mem_re    = 1'b1;
            w_mem_addr  = io_bus.p0_addr;
        end
        // Dropped push/pop fall through with every strobe low.
    end

    assign io_bus.mem_we    = w_mem_we;
    assign io_bus.mem_re    = w_mem_re;
    assign io_bus.mem_cs    = w_mem_we || w_mem_re;
    assign io_bus.mem_addr  = w_mem_addr;
    assign io_bus.mem_wdata = w_mem_wdata;

    // Port 0 only stalls when port 1 is forced over a pending op; dropped
    // stack ops complete (as errors) and do not stall.
    assign io_bus.p0_stall = w_p0_has_op && w_p1_grant;
    assign io_bus.p1_ack   = w_p1_grant;

    // ------------------------------------------------------------------------
    // Stack pointer and sticky error flags
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp        <= SP_RESET;
            r_stack_ovf <= 1'b0;
            r_stack_unf <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_sp <= r_sp - 16'd1;
            end else if (w_pop_ok) begin
                r_sp <= w_sp_inc;
            end
            if (w_push_ovf) begin
                r_stack_ovf <= 1'b1;
            end
            if (w_pop_unf) begin
                r_stack_unf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Starvation counter: counts cycles port 1 waits, saturates at the limit.
    // Dropping p1_req abandons the request and restarts the count.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!io_bus.p1_req || w_p1_grant) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Read tracking
    // ------------------------------------------------------------------------
    logic [1:0] w_rd_owner_next;

    always_comb begin
        w_rd_owner_next = OWN_NONE;
        if (w_p1_grant && !io_bus.p1_we) begin
            w_rd_owner_next = OWN_P1;
        end else if (w_pop_ok || w_read_ok) begin
            w_rd_owner_next = OWN_P0;
        end else if (w_pop_unf) begin
            w_rd_owner_next = OWN_P0_ZERO;
        end
    end

    // The owner register is cleared asynchronously, so a read in flight when
    // reset hits never produces an rvalid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_owner <= OWN_NONE;
            r_p0_rdata <= 16'h0000;
            r_p1_rdata <= 16'h0000;
        end else begin
            r_rd_owner <= w_rd_owner_next;
            case (r_rd_owner)
                OWN_P0:      r_p0_rdata <= io_bus.mem_rdata;
                OWN_P0_ZERO: r_p0_rdata <= 16'h0000;
                OWN_P1:      r_p1_rdata <= io_bus.mem_rdata;
                default:     ;
            endcase
        end
    end

    // Memory data lands the cycle after issue, which is also the rvalid
    // cycle. The rdata outputs bypass to mem_rdata in that cycle and then
    // hold the captured value until the next read for the same port.
    logic w_p0_rvalid;
    logic w_p1_rvalid;

    assign w_p0_rvalid = (r_rd_owner == OWN_P0) || (r_rd_owner == OWN_P0_ZERO);
    assign w_p1_rvalid = (r_rd_owner == OWN_P1);

    assign io_bus.p0_rvalid = w_p0_rvalid;
    assign io_bus.p1_rvalid = w_p1_rvalid;
    assign io_bus.p0_rdata  = (r_rd_owner == OWN_P0)      ? io_bus.mem_rdata :
                              (r_rd_owner == OWN_P0_ZERO) ? 16'h0000 :
                                                            r_p0_rdata;
    assign io_bus.p1_rdata  = w_p1_rvalid ? io_bus.mem_rdata : r_p1_rdata;

    assign o_sp        = r_sp;
    assign o_stack_ovf = r_stack_ovf;
    assign o_stack_unf = r_stack_unf;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. A small synchronous memory model answers
// reads one cycle after mem_re. Inputs change on the falling edge; outputs
// are sampled on the falling edge or 1 time unit after it.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sp;
    logic        stack_ovf;
    logic        stack_unf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .io_bus      (bus),
        .o_sp        (sp),
        .o_stack_ovf (stack_ovf),
        .o_stack_unf (stack_unf)
    );

    // Synchronous data memory: write on cs&we, registered read data.
    logic [15:0] mem [0:65535];
    logic [15:0] mem_q = 16'h0000;

    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_cs && bus.mem_re) mem_q <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = mem_q;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; returns on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.p0_read  = 1'b0;
        bus.p0_write = 1'b0;
        bus.p0_push  = 1'b0;
        bus.p0_pop   = 1'b0;
        bus.p0_addr  = 16'h0000;
        bus.p0_wdata = 16'h0000;
        bus.p1_req   = 1'b0;
        bus.p1_we    = 1'b0;
        bus.p1_addr  = 16'h0000;
        bus.p1_wdata = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        logic [15:0] e;

        // ---------------- reset state, requests held during reset ----------
        clear_inputs();
        rst = 1'b1;
        bus.p0_push = 1'b1;
        bus.p1_req  = 1'b1;
        bus.p1_we   = 1'b1;
        bus.p1_addr = 16'h0020;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_cs",   16'(bus.mem_cs),    16'd0);
        check("rst_p1_ack",   16'(bus.p1_ack),    16'd0);
        check("rst_sp",       sp,                 16'h0FFF);
        check("rst_ovf",      16'(stack_ovf),     16'd0);
        check("rst_unf",      16'(stack_unf),     16'd0);
        check("rst_p0_rvld",  16'(bus.p0_rvalid), 16'd0);
        check("rst_p1_rvld",  16'(bus.p1_rvalid), 16'd0);
        check("rst_p0_rdata", bus.p0_rdata,       16'h0000);
        check("rst_p1_rdata", bus.p1_rdata,       16'h0000);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;

        // ---------------- push AAAA, push BBBB, pop, pop --------------------
        bus.p0_push  = 1'b1;
        bus.p0_wdata = 16'hAAAA;
        #1;
        check("push1_we",    16'(bus.mem_we),   16'd1);
        check("push1_addr",  bus.mem_addr,      16'h0FFF);
        check("push1_wdata", bus.mem_wdata,     16'hAAAA);
        check("push1_stall", 16'(bus.p0_stall), 16'd0);
        step();
        check("push1_sp", sp, 16'h0FFE);
        bus.p0_wdata = 16'hBBBB;
        #1;
        check("push2_addr",  bus.mem_addr,    16'h0FFE);
        check("push2_we",    16'(bus.mem_we), 16'd1);
        step();
        check("push2_sp", sp, 16'h0FFD);
        bus.p0_push = 1'b0;
        bus.p0_pop  = 1'b1;
        #1;
        check("pop1_re",   16'(bus.mem_re), 16'd1);
        check("pop1_addr", bus.mem_addr,    16'h0FFE);
        step();
        check("pop1_sp",    sp,                 16'h0FFE);
        check("pop1_rvld",  16'(bus.p0_rvalid), 16'd1);
        check("pop1_rdata", bus.p0_rdata,       16'hBBBB);
        #1;
        check("pop2_addr", bus.mem_addr, 16'h0FFF);
        step();
        check("pop2_sp",    sp,                 16'h0FFF);
        check("pop2_rvld",  16'(bus.p0_rvalid), 16'd1);
        check("pop2_rdata", bus.p0_rdata,       16'hAAAA);

        // ---------------- underflow: pop on empty stack --------------------
        #1;
        check("unf_cs",    16'(bus.mem_cs),   16'd0);
        check("unf_stall", 16'(bus.p0_stall), 16'd0);
        step();
        bus.p0_pop = 1'b0;
        check("unf_flag",  16'(stack_unf),     16'd1);
        check("unf_sp",    sp,                 16'h0FFF);
        check("unf_rvld",  16'(bus.p0_rvalid), 16'd1);
        check("unf_rdata", bus.p0_rdata,       16'h0000);
        step();
        check("unf_rvld_end", 16'(bus.p0_rvalid), 16'd0);

        // ---------------- fill the stack, then overflow --------------------
        check("pre_ovf_flag", 16'(stack_ovf), 16'd0);
        bus.p0_push = 1'b1;
        for (int k = 0; k < 2048; k++) begin
            bus.p0_wdata = ~(16'h0FFF - 16'(k));
            step();
        end
        check("fill_sp",       sp,              16'h07FF);
        check("fill_ovf_flag", 16'(stack_ovf),  16'd0);
        bus.p0_wdata = 16'hDEAD;
        #1;
        check("ovf_cs",    16'(bus.mem_cs),   16'd0);
        check("ovf_stall", 16'(bus.p0_stall), 16'd0);
        step();
        bus.p0_push = 1'b0;
        check("ovf_flag",        16'(stack_ovf), 16'd1);
        check("ovf_sp",          sp,             16'h07FF);
        check("unf_flag_sticky", 16'(stack_unf), 16'd1);

        // ---------------- port 1 alone: write then read --------------------
        bus.p1_req   = 1'b1;
        bus.p1_we    = 1'b1;
        bus.p1_addr  = 16'h0010;
        bus.p1_wdata = 16'h1234;
        #1;
        check("p1w_ack",   16'(bus.p1_ack),   16'd1);
        check("p1w_we",    16'(bus.mem_we),   16'd1);
        check("p1w_addr",  bus.mem_addr,      16'h0010);
        check("p1w_wdata", bus.mem_wdata,     16'h1234);
        step();
        bus.p1_we = 1'b0;
        #1;
        check("p1r_ack", 16'(bus.p1_ack), 16'd1);
        check("p1r_re",  16'(bus.mem_re), 16'd1);
        step();
        bus.p1_req = 1'b0;
        check("p1r_rvld",  16'(bus.p1_rvalid), 16'd1);
        check("p1r_rdata", bus.p1_rdata,       16'h1234);

        // ---------------- abandoned port-1 request -------------------------
        bus.p0_read = 1'b1;
        bus.p0_addr = 16'h0A00;
        bus.p1_req  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("abandon_ack", 16'(bus.p1_ack), 16'd0);
            step();
        end
        bus.p1_req = 1'b0;
        #1;
        check("abandon_ack_low", 16'(bus.p1_ack), 16'd0);
        check("abandon_addr",    bus.mem_addr,    16'h0A00);
        step();

        // ---------------- starvation: p1 forced on the 5th cycle -----------
        bus.p1_req  = 1'b1;
        bus.p1_we   = 1'b0;
        bus.p1_addr = 16'h0010;
        for (int c = 1; c <= 5; c++) begin
            bus.p0_addr = 16'h0900 + 16'(c);
            #1;
            check("starve_ack",   16'(bus.p1_ack),   (c == 5) ? 16'd1 : 16'd0);
            check("starve_stall", 16'(bus.p0_stall), (c == 5) ? 16'd1 : 16'd0);
            check("starve_addr",  bus.mem_addr,      (c == 5) ? 16'h0010 : bus.p0_addr);
            if (c >= 2) begin
                a = 16'h0900 + 16'(c - 1);
                e = ~a;
                check("starve_p0_rdata", bus.p0_rdata,       e);
                check("starve_p0_rvld",  16'(bus.p0_rvalid), 16'd1);
            end
            step();
        end
        bus.p1_req = 1'b0;
        check("starve_p1_rvld",  16'(bus.p1_rvalid), 16'd1);
        check("starve_p1_rdata", bus.p1_rdata,       16'h1234);
        check("starve_p0_gap",   16'(bus.p0_rvalid), 16'd0);
        #1;
        check("retry_stall", 16'(bus.p0_stall), 16'd0);
        check("retry_addr",  bus.mem_addr,      16'h0905);
        step();
        bus.p0_read = 1'b0;
        check("retry_rvld",  16'(bus.p0_rvalid), 16'd1);
        check("retry_rdata", bus.p0_rdata,       16'hF6FA);

        // ---------------- reset during an outstanding read -----------------
        bus.p0_read = 1'b1;
        bus.p0_addr = 16'h0800;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.p0_read = 1'b0;
        @(negedge clk);
        check("midrst_rvld", 16'(bus.p0_rvalid), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_rvld", 16'(bus.p0_rvalid), 16'd0);
        check("postrst_sp",   sp,                 16'h0FFF);
        check("postrst_ovf",  16'(stack_ovf),     16'd0);
        check("postrst_unf",  16'(stack_unf),     16'd0);
        step();
        check("postrst_rvld2", 16'(bus.p0_rvalid), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
